chs_power_scheduler: RTL and testbench

//   Admits channel power requests against a shared power budget. Each channel presents a 4-bit power level and mode

---
 rtl/chs_pkg.sv | 16 +
 rtl/chs_power_scheduler_rr_ptr.sv | 27 ++
 rtl/chs_power_scheduler.sv | 174 +++++++++++++++++
 tb/tb_chs_power_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/chs_pkg.sv
// chs_pkg: shared definitions for the channel power scheduler.
//   state_t    scheduler FSM encoding (S_IDLE, S_EVAL, S_COMMIT)
//   CHS_PWR_W  default width of one channel power level
//   CHS_IDX_W  width of a channel index (grant_id, preempt_id, pointer)
package chs_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EVAL   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    localparam int CHS_PWR_W = 4;
    localparam int CHS_IDX_W = 3;

endpackage : chs_pkg

// File: rtl/chs_power_scheduler_rr_ptr.sv
// rr_ptr: round-robin channel pointer.
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (pointer returns to 0)
//   advance  step the pointer by one, wrapping from NUM_CH-1 to 0
//   ptr      current channel index
module rr_ptr
    import chs_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 advance,
    output logic [CHS_IDX_W-1:0] ptr
);

    localparam logic [CHS_IDX_W-1:0] LAST = CHS_IDX_W'(NUM_CH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
        end
    end

endmodule : rr_ptr

// File: rtl/chs_power_scheduler.sv
// chs_power_scheduler: admits per-channel power requests round-robin against a
// shared power budget and tracks the power held by granted channels.
//   clk, rst_n      clock, asynchronous active-low reset
//   budget          total power allowed (sampled every cycle)
//   req             level request per channel
//   req_power       packed power levels, channel i at [i*PWR_W +: PWR_W]
//   req_mode        per-channel mode (only meaningful with PWR_PREEMPT_EN)
//   release_pulse   one-cycle pulse per channel: channel turns off
//   active          channel holds a grant
//   grant_vld/id    one-cycle pulse and channel index of a committed grant
//   used_power      sum of latched power of active channels
//   preempt_vld/id  (PWR_PREEMPT_EN only) revocation pulse and channel index
// Optional feature macro: PWR_PREEMPT_EN (mode-1 requests may revoke the
// highest-index active mode-0 channel until they fit).
module chs_power_scheduler
    import chs_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int PWR_W    = CHS_PWR_W,
    parameter int BUDGET_W = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [BUDGET_W-1:0]     budget,
    input  logic [NUM_CH-1:0]       req,
    input  logic [NUM_CH*PWR_W-1:0] req_power,
    input  logic [NUM_CH-1:0]       req_mode,
    input  logic [NUM_CH-1:0]       release_pulse,
    output logic [NUM_CH-1:0]       active,
    output logic                    grant_vld,
    output logic [CHS_IDX_W-1:0]    grant_id,
`ifdef PWR_PREEMPT_EN
    output logic                    preempt_vld,
    output logic [CHS_IDX_W-1:0]    preempt_id,
`endif
    output logic [BUDGET_W-1:0]     used_power
);

    state_t               state, state_nxt;
    logic [CHS_IDX_W-1:0] ptr;
    logic                 ptr_adv;
    logic [PWR_W-1:0]     pwr_lat [NUM_CH];
    logic [PWR_W-1:0]     cap_pwr;
    logic [PWR_W-1:0]     ptr_pwr;
    logic [BUDGET_W:0]    fit_sum;
    logic                 fits;
    logic [NUM_CH-1:0]    pending, pending_nxt, rel_mask, commit_mask, revoke_mask, active_nxt;
    logic                 capture, commit, revoke;
    logic [BUDGET_W-1:0]  rel_sum, revoke_pwr, used_nxt;

    rr_ptr #(.NUM_CH(NUM_CH)) u_rr_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (ptr_adv),
        .ptr     (ptr)
    );

    // One extra bit on the fit sum so used_power + request never wraps.
    assign ptr_pwr = req_power[int'(ptr)*PWR_W +: PWR_W];
    assign fit_sum = {1'b0, used_power} + (BUDGET_W+1)'(ptr_pwr);
    assign fits    = (fit_sum <= {1'b0, budget});

    assign pending  = req & ~active;
    assign rel_mask = release_pulse & active;

    // The channel under the pointer is still in COMMIT; ptr has not moved since EVAL.
    assign capture     = (state == S_EVAL) && pending[ptr] && fits;
    assign commit      = (state == S_COMMIT) && req[ptr];
    assign commit_mask = commit ? (NUM_CH'(1) << ptr) : '0;

`ifdef PWR_PREEMPT_EN
    logic [NUM_CH-1:0]    mode_lat;
    logic [CHS_IDX_W-1:0] victim;
    logic                 victim_found;

    // Highest-index active mode-0 channel wins; channels releasing this cycle are excluded
    // so their power is not subtracted twice.
    always_comb begin
        victim       = '0;
        victim_found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (active[i] && !mode_lat[i] && !rel_mask[i]) begin
                victim       = CHS_IDX_W'(i);
                victim_found = 1'b1;
            end
        end
    end

    assign revoke      = (state == S_EVAL) && pending[ptr] && !fits && req_mode[ptr] && victim_found;
    assign revoke_mask = revoke ? (NUM_CH'(1) << victim) : '0;
    assign revoke_pwr  = revoke ? BUDGET_W'(pwr_lat[victim]) : '0;
`else
    logic mode_unused;
    assign mode_unused = ^req_mode;
    assign revoke      = 1'b0;
    assign revoke_mask = '0;
    assign revoke_pwr  = '0;
`endif

    assign active_nxt  = (active & ~rel_mask & ~revoke_mask) | commit_mask;
    assign pending_nxt = req & ~active_nxt;

    always_comb begin
        rel_sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rel_mask[i]) rel_sum = rel_sum + BUDGET_W'(pwr_lat[i]);
        end
    end

    assign used_nxt = used_power + (commit ? BUDGET_W'(cap_pwr) : '0) - rel_sum - revoke_pwr;

    always_comb begin
        state_nxt = state;
        ptr_adv   = 1'b0;
        case (state)
            S_IDLE: begin
                if (|pending) state_nxt = S_EVAL;
            end
            S_EVAL: begin
                if (capture) begin
                    state_nxt = S_COMMIT;
                end else if (!revoke) begin
                    // A revocation holds the pointer so the same request is re-checked next cycle.
                    ptr_adv   = 1'b1;
                    state_nxt = (|pending_nxt) ? S_EVAL : S_IDLE;
                end
            end
            S_COMMIT: begin
                ptr_adv   = 1'b1;
                state_nxt = (|pending_nxt) ? S_EVAL : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            active     <= '0;
            used_power <= '0;
            grant_vld  <= 1'b0;
            grant_id   <= '0;
            cap_pwr    <= '0;
            for (int i = 0; i < NUM_CH; i++) pwr_lat[i] <= '0;
        end else begin
            state      <= state_nxt;
            active     <= active_nxt;
            used_power <= used_nxt;
            grant_vld  <= commit;
            if (commit) grant_id <= ptr;
            if (capture) cap_pwr <= ptr_pwr;
            for (int i = 0; i < NUM_CH; i++) begin
                if (commit_mask[i]) pwr_lat[i] <= cap_pwr;
            end
        end
    end

`ifdef PWR_PREEMPT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_lat    <= '0;
            preempt_vld <= 1'b0;
            preempt_id  <= '0;
        end else begin
            preempt_vld <= revoke;
            if (revoke) preempt_id <= victim;
            for (int i = 0; i < NUM_CH; i++) begin
                if (commit_mask[i]) mode_lat[i] <= req_mode[i];
            end
        end
    end
`endif

endmodule : chs_power_scheduler

// File: tb/tb_chs_power_scheduler.sv
// tb_chs_power_scheduler: directed self-checking bench for chs_power_scheduler
// (NUM_CH=4, PWR_W=4, BUDGET_W=6). Inputs change 1 ns after a rising edge and
// outputs are sampled at the same point.
module tb_chs_power_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  budget;
    logic [3:0]  req;
    logic [15:0] req_power;
    logic [3:0]  req_mode;
    logic [3:0]  release_pulse;
    logic [3:0]  active;
    logic        grant_vld;
    logic [2:0]  grant_id;
    logic [5:0]  used_power;
`ifdef PWR_PREEMPT_EN
    logic        preempt_vld;
    logic [2:0]  preempt_id;
`endif

    int total = 0;
    int bad   = 0;

    chs_power_scheduler #(.NUM_CH(4), .PWR_W(4), .BUDGET_W(6)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .budget        (budget),
        .req           (req),
        .req_power     (req_power),
        .req_mode      (req_mode),
        .release_pulse (release_pulse),
        .active        (active),
        .grant_vld     (grant_vld),
        .grant_id      (grant_id),
`ifdef PWR_PREEMPT_EN
        .preempt_vld   (preempt_vld),
        .preempt_id    (preempt_id),
`endif
        .used_power    (used_power)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        budget        = '0;
        req           = '0;
        req_power     = '0;
        req_mode      = '0;
        release_pulse = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (active !== 4'b0000) begin bad++; $display("FAIL reset_active got=%b exp=0000", active); end
        total++; if (used_power !== 6'd0) begin bad++; $display("FAIL reset_used got=%0d exp=0", used_power); end
        total++; if (grant_vld !== 1'b0) begin bad++; $display("FAIL reset_grant_vld got=%b exp=0", grant_vld); end
        total++; if (grant_id !== 3'd0) begin bad++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
    endtask

    task automatic test_single_grant();
        do_reset();
        budget    = 6'd16;
        req_power = {4'd0, 4'd0, 4'd0, 4'd5};
        req       = 4'b0001;
        tick();
        total++; if (grant_vld !== 1'b0) begin bad++; $display("FAIL single_early1 got=%b exp=0", grant_vld); end
        tick();
        total++; if (grant_vld !== 1'b0) begin bad++; $display("FAIL single_early2 got=%b exp=0", grant_vld); end
        tick();
        total++; if (grant_vld !== 1'b1) begin bad++; $display("FAIL single_grant_vld got=%b exp=1", grant_vld); end
        total++; if (grant_id !== 3'd0) begin bad++; $display("FAIL single_grant_id got=%0d exp=0", grant_id); end
        total++; if (active !== 4'b0001) begin bad++; $display("FAIL single_active got=%b exp=0001", active); end
        total++; if (used_power !== 6'd5) begin bad++; $display("FAIL single_used got=%0d exp=5", used_power); end
        tick();
        total++; if (grant_vld !== 1'b0) begin bad++; $display("FAIL single_pulse got=%b exp=0", grant_vld); end
    endtask

    task automatic test_budget_block();
        int n;
        int extra;
        do_reset();
        budget    = 6'd10;
        req_power = {4'd0, 4'd0, 4'd6, 4'd6};
        req       = 4'b0011;
        n = 0;
        do begin tick(); n++; end while (grant_vld !== 1'b1 && n < 20);
        total++; if (grant_vld !== 1'b1 || grant_id !== 3'd0) begin bad++; $display("FAIL block_first vld=%b id=%0d exp vld=1 id=0", grant_vld, grant_id); end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (grant_vld === 1'b1) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL block_no_ch1 grants=%0d exp=0", extra); end
        total++; if (active !== 4'b0001 || used_power !== 6'd6) begin bad++; $display("FAIL block_hold active=%b used=%0d exp 0001/6", active, used_power); end
        release_pulse = 4'b0001;
        req           = 4'b0010;
        tick();
        release_pulse = 4'b0000;
        n = 0;
        while (grant_vld !== 1'b1 && n < 12) begin tick(); n++; end
        total++; if (grant_vld !== 1'b1 || grant_id !== 3'd1) begin bad++; $display("FAIL block_second vld=%b id=%0d exp vld=1 id=1", grant_vld, grant_id); end
        total++; if (used_power !== 6'd6 || active !== 4'b0010) begin bad++; $display("FAIL block_second_state used=%0d active=%b exp 6/0010", used_power, active); end
    endtask

    task automatic test_no_stall();
        int ids [3];
        int cnt;
        do_reset();
        budget    = 6'd12;
        req_power = {4'd3, 4'd15, 4'd3, 4'd3};
        req       = 4'b1111;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (grant_vld === 1'b1) begin
                if (cnt < 3) ids[cnt] = int'(grant_id);
                cnt++;
            end
        end
        total++; if (cnt !== 3) begin bad++; $display("FAIL nostall_count got=%0d exp=3", cnt); end
        total++; if (cnt >= 3 && (ids[0] !== 0 || ids[1] !== 1 || ids[2] !== 3)) begin bad++; $display("FAIL nostall_order got=%0d,%0d,%0d exp=0,1,3", ids[0], ids[1], ids[2]); end
        total++; if (active !== 4'b1011 || used_power !== 6'd9) begin bad++; $display("FAIL nostall_state active=%b used=%0d exp 1011/9", active, used_power); end
    endtask

    task automatic test_commit_release();
        int n;
        do_reset();
        budget    = 6'd16;
        req_power = {4'd0, 4'd0, 4'd4, 4'd0};
        req       = 4'b0010;
        n = 0;
        do begin tick(); n++; end while (grant_vld !== 1'b1 && n < 20);
        total++; if (grant_id !== 3'd1 || used_power !== 6'd4) begin bad++; $display("FAIL cr_first id=%0d used=%0d exp 1/4", grant_id, used_power); end
        req_power = {4'd7, 4'd0, 4'd4, 4'd0};
        req       = 4'b1010;
        tick();
        tick();
        tick();
        total++; if (used_power !== 6'd4) begin bad++; $display("FAIL cr_before used=%0d exp=4", used_power); end
        release_pulse = 4'b0010;
        req           = 4'b1000;
        tick();
        release_pulse = 4'b0000;
        total++; if (used_power !== 6'd7) begin bad++; $display("FAIL cr_used got=%0d exp=7", used_power); end
        total++; if (active !== 4'b1000) begin bad++; $display("FAIL cr_active got=%b exp=1000", active); end
        total++; if (grant_vld !== 1'b1 || grant_id !== 3'd3) begin bad++; $display("FAIL cr_grant vld=%b id=%0d exp 1/3", grant_vld, grant_id); end
        release_pulse = 4'b0001;
        req_power     = {4'd15, 4'd0, 4'd4, 4'd0};
        tick();
        release_pulse = 4'b0000;
        tick();
        total++; if (used_power !== 6'd7 || active !== 4'b1000) begin bad++; $display("FAIL cr_ignore used=%0d active=%b exp 7/1000", used_power, active); end
        release_pulse = 4'b1000;
        req           = 4'b0000;
        tick();
        release_pulse = 4'b0000;
        total++; if (used_power !== 6'd0 || active !== 4'b0000) begin bad++; $display("FAIL cr_latched used=%0d active=%b exp 0/0000", used_power, active); end
    endtask

    task automatic test_abort_and_async_reset();
        int n;
        do_reset();
        budget    = 6'd16;
        req_power = {4'd0, 4'd0, 4'd0, 4'd5};
        req       = 4'b0001;
        tick();
        tick();
        req = 4'b0000;
        tick();
        total++; if (grant_vld !== 1'b0) begin bad++; $display("FAIL abort_vld got=%b exp=0", grant_vld); end
        total++; if (used_power !== 6'd0 || active !== 4'b0000) begin bad++; $display("FAIL abort_state used=%0d active=%b exp 0/0000", used_power, active); end
        req_power = {4'd0, 4'd0, 4'd9, 4'd0};
        req       = 4'b0010;
        n = 0;
        do begin tick(); n++; end while (grant_vld !== 1'b1 && n < 20);
        total++; if (grant_id !== 3'd1 || used_power !== 6'd9) begin bad++; $display("FAIL async_pre id=%0d used=%0d exp 1/9", grant_id, used_power); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (active !== 4'b0000 || used_power !== 6'd0 || grant_vld !== 1'b0 || grant_id !== 3'd0) begin
            bad++; $display("FAIL async_reset active=%b used=%0d vld=%b id=%0d exp all 0", active, used_power, grant_vld, grant_id);
        end
        tick();
        rst_n = 1'b1;
    endtask

`ifdef PWR_PREEMPT_EN
    task automatic test_preempt();
        int n;
        do_reset();
        budget    = 6'd8;
        req_power = {4'd0, 4'd0, 4'd0, 4'd6};
        req_mode  = 4'b0000;
        req       = 4'b0001;
        n = 0;
        do begin tick(); n++; end while (grant_vld !== 1'b1 && n < 20);
        total++; if (active !== 4'b0001 || used_power !== 6'd6) begin bad++; $display("FAIL pre_setup active=%b used=%0d exp 0001/6", active, used_power); end
        req_power = {4'd0, 4'd0, 4'd5, 4'd6};
        req_mode  = 4'b0010;
        req       = 4'b0011;
        n = 0;
        do begin tick(); n++; end while (preempt_vld !== 1'b1 && n < 20);
        total++; if (preempt_vld !== 1'b1 || preempt_id !== 3'd0) begin bad++; $display("FAIL pre_revoke vld=%b id=%0d exp 1/0", preempt_vld, preempt_id); end
        total++; if (active !== 4'b0000 || used_power !== 6'd0) begin bad++; $display("FAIL pre_revoked active=%b used=%0d exp 0000/0", active, used_power); end
        n = 0;
        do begin tick(); n++; end while (grant_vld !== 1'b1 && n < 20);
        total++; if (grant_vld !== 1'b1 || grant_id !== 3'd1) begin bad++; $display("FAIL pre_grant vld=%b id=%0d exp 1/1", grant_vld, grant_id); end
        total++; if (used_power !== 6'd5 || active !== 4'b0010) begin bad++; $display("FAIL pre_final used=%0d active=%b exp 5/0010", used_power, active); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_grant();
        test_budget_block();
        test_no_stall();
        test_commit_release();
        test_abort_and_async_reset();
`ifdef PWR_PREEMPT_EN
        test_preempt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_chs_power_scheduler
